uart_baud_gen: RTL and testbench
================================

UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 Parameter DIV_W, 16, width of integer divisor.
REQ-002 Parameter FRAC_W, 4, width of fractional divisor.
REQ-003 Parameter OVERSAMPLE, 16, oversample ticks per bit; power of two, >= 4.
REQ-004 Parameter RST_DIV, 14, integer divisor after reset; must be >= 2.
REQ-005 clk  in  1  system clock.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_enable  in  1  generator run enable.
REQ-008 i_div_int  in  DIV_W  requested integer divisor, clk cycles per oversample tick.
REQ-009 i_div_frac  in  FRAC_W  requested fractional divisor, in units of 1/2^FRAC_W cycle.
REQ-010 i_div_load  in  1  single-cycle pulse; requests divisor update.
REQ-011 i_rx_resync  in  1  single-cycle pulse; realigns RX phase (start-bit edge).
REQ-012 o_os_tick  out  1  one-cycle pulse at oversample rate.
REQ-013 o_tx_tick  out  1  one-cycle pulse at bit rate.
REQ-014 o_rx_sample  out  1  one-cycle pulse at RX mid-bit sample point.
REQ-015 o_div_err  out  1  sticky flag, last load request rejected.

Function
REQ-016 All outputs SHALL be single-cycle pulses from registers, except o_div_err (level).
REQ-017 Active divisor (int, frac) SHALL be held in a shadow register separate from inputs.
REQ-018 On i_div_load with i_div_int >= 2: pending divisor captured; applied at next prescaler wrap, or in the same cycle when i_enable low; o_div_err cleared.
REQ-019 On i_div_load with i_div_int < 2: request discarded, active divisor unchanged, o_div_err set next cycle.
REQ-020 Prescaler SHALL count 0..P-1 and assert o_os_tick in the cycle it equals P-1, then wrap to 0; P = div_int, or div_int+1 when current fractional carry is set.
REQ-021 Fractional accumulator (FRAC_W bits) SHALL add div_frac at each o_os_tick; carry-out sets extend flag for the following period; average period = div_int + div_frac/2^FRAC_W cycles.
REQ-022 TX phase counter SHALL count o_os_tick modulo OVERSAMPLE; o_tx_tick asserted coincident with o_os_tick when TX phase == OVERSAMPLE-1.
REQ-023 RX phase counter SHALL count o_os_tick modulo OVERSAMPLE independently; o_rx_sample asserted coincident with o_os_tick when RX phase == OVERSAMPLE/2-1.
REQ-024 i_rx_resync SHALL clear RX phase counter and prescaler; TX phase and accumulator unaffected; o_os_tick suppressed that cycle.
REQ-025 i_rx_resync coincident with prescaler terminal count: resync wins, no tick, no phase advance.
REQ-026 i_div_load coincident with prescaler wrap: new divisor governs the immediately following period.
REQ-027 i_enable low: prescaler, phase counters, accumulator held at 0; all tick outputs 0; divisor loads still accepted.
REQ-028 After i_enable rises, first o_os_tick SHALL occur exactly div_int cycles later.

Reset
REQ-029 reset_n low SHALL asynchronously clear all counters, accumulator, outputs, o_div_err; active divisor = RST_DIV, frac 0; no pending load.
REQ-030 Reset mid-period SHALL abandon the period; no tick emitted on release.

Configuration
REQ-031 Macro UART_BAUD_FRAC_EN defined: fractional accumulator and extend logic present per REQ-021.
REQ-032 Macro UART_BAUD_FRAC_EN undefined: i_div_frac port retained but ignored, no accumulator, period exactly div_int; all other behaviour identical.

Verification
REQ-033 Reset, enable, div_int=14, frac=0 -> o_os_tick every 14 cycles, o_tx_tick every 224 cycles, first os tick 14 cycles after enable.
REQ-034 FRAC_EN, div_int=13, frac=9 -> over 16 ticks, 9 periods of 14 and 7 of 13 cycles, total 217 cycles.
REQ-035 i_rx_resync at arbitrary cycle, div_int=10 -> o_rx_sample exactly 80 cycles after resync; TX tick spacing undisturbed.
REQ-036 i_div_load div_int=1 -> o_div_err=1, period stays 14; then load 20 -> o_div_err=0, period 20 from next wrap.
REQ-037 i_rx_resync on terminal-count cycle -> no o_os_tick that cycle, RX phase 0.
REQ-038 reset_n asserted mid-period with ticks pending -> all outputs 0 immediately, divisor back to 14.

Source files
------------

// File: rtl/uart_baud_gen.sv
// UART baud generator: fractional-N prescaler producing oversample, TX bit and RX mid-bit ticks.
// Optional macro UART_BAUD_FRAC_EN enables the fractional accumulator; otherwise the period is exactly div_int.
module uart_baud_gen #(
   parameter int DIV_W      = 16,
   parameter int FRAC_W     = 4,
   parameter int OVERSAMPLE = 16,
   parameter int RST_DIV    = 14
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_enable,
   input  logic [DIV_W-1:0]  i_div_int,
   input  logic [FRAC_W-1:0] i_div_frac,
   input  logic              i_div_load,
   input  logic              i_rx_resync,
   output logic              o_os_tick,
   output logic              o_tx_tick,
   output logic              o_rx_sample,
   output logic              o_div_err
);

   localparam int                PH_W    = $clog2(OVERSAMPLE);
   localparam logic [PH_W-1:0]   TX_LAST = PH_W'(OVERSAMPLE - 1);
   localparam logic [PH_W-1:0]   RX_LAST = PH_W'(OVERSAMPLE / 2 - 1);

   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [PH_W-1:0]   tx_ph_q, tx_ph_d;
   logic [PH_W-1:0]   rx_ph_q, rx_ph_d;
   logic [DIV_W-1:0]  div_int_q, div_int_d;
   logic [FRAC_W-1:0] div_frac_q, div_frac_d;
   logic [DIV_W-1:0]  pend_int_q, pend_int_d;
   logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
   logic              pend_v_q, pend_v_d;
   logic              err_q, err_d;
   logic              os_q, os_d;
   logic              tx_q, tx_d;
   logic              rx_q, rx_d;

   logic              ext_s;
   logic              term_s;
   logic              wrap_s;
   logic              apply_s;
   logic              div_ok_s;

   assign div_ok_s = (i_div_int >= DIV_W'(2));
   // Terminal count is P-1 where P is div_int, stretched by one when the carry flag is set.
   assign term_s   = i_enable & (ext_s ? (cnt_q == div_int_q) : (cnt_q == (div_int_q - DIV_W'(1))));
   assign wrap_s   = term_s & ~i_rx_resync;
   assign apply_s  = wrap_s | ~i_enable;

   // Prescaler and phase counters; the resync cycle itself counts as prescaler count 0.
   always_comb begin
      cnt_d   = cnt_q;
      tx_ph_d = tx_ph_q;
      rx_ph_d = rx_ph_q;
      if (!i_enable) begin
         cnt_d   = '0;
         tx_ph_d = '0;
         rx_ph_d = '0;
      end else if (i_rx_resync) begin
         cnt_d   = DIV_W'(1);
         rx_ph_d = '0;
      end else if (term_s) begin
         cnt_d   = '0;
         tx_ph_d = tx_ph_q + PH_W'(1);
         rx_ph_d = rx_ph_q + PH_W'(1);
      end else begin
         cnt_d   = cnt_q + DIV_W'(1);
      end
   end

   // Tick outputs are computed one cycle ahead and registered.
   always_comb begin
      os_d = wrap_s;
      tx_d = wrap_s & (tx_ph_q == TX_LAST);
      rx_d = wrap_s & (rx_ph_q == RX_LAST);
   end

   // Divisor shadow: direct apply on wrap/idle, otherwise park in the pending slot.
   always_comb begin
      div_int_d   = div_int_q;
      div_frac_d  = div_frac_q;
      pend_int_d  = pend_int_q;
      pend_frac_d = pend_frac_q;
      pend_v_d    = pend_v_q;
      err_d       = err_q;
      if (i_div_load && div_ok_s) begin
         err_d = 1'b0;
         if (apply_s) begin
            div_int_d  = i_div_int;
            div_frac_d = i_div_frac;
            pend_v_d   = 1'b0;
         end else begin
            pend_int_d  = i_div_int;
            pend_frac_d = i_div_frac;
            pend_v_d    = 1'b1;
         end
      end else begin
         err_d = i_div_load ? 1'b1 : err_q;
         if (apply_s && pend_v_q) begin
            div_int_d  = pend_int_q;
            div_frac_d = pend_frac_q;
            pend_v_d   = 1'b0;
         end else begin
            pend_v_d   = pend_v_q;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         tx_ph_q     <= '0;
         rx_ph_q     <= '0;
         div_int_q   <= DIV_W'(RST_DIV);
         div_frac_q  <= '0;
         pend_int_q  <= '0;
         pend_frac_q <= '0;
         pend_v_q    <= 1'b0;
         err_q       <= 1'b0;
         os_q        <= 1'b0;
         tx_q        <= 1'b0;
         rx_q        <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         tx_ph_q     <= tx_ph_d;
         rx_ph_q     <= rx_ph_d;
         div_int_q   <= div_int_d;
         div_frac_q  <= div_frac_d;
         pend_int_q  <= pend_int_d;
         pend_frac_q <= pend_frac_d;
         pend_v_q    <= pend_v_d;
         err_q       <= err_d;
         os_q        <= os_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
      end
   end

`ifdef UART_BAUD_FRAC_EN
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic              ext_q, ext_d;

   // Fractional accumulator; its carry stretches the following period by one cycle.
   always_comb begin
      acc_d = acc_q;
      ext_d = ext_q;
      if (!i_enable) begin
         acc_d = '0;
         ext_d = 1'b0;
      end else if (wrap_s) begin
         {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, div_frac_q};
      end else begin
         acc_d = acc_q;
         ext_d = ext_q;
      end
   end

   // Accumulator registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
         ext_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ext_q <= ext_d;
      end
   end

   assign ext_s = ext_q;
`else
   logic unused_frac_s;
   assign unused_frac_s = ^div_frac_q;
   assign ext_s         = 1'b0;
`endif

   assign o_os_tick   = os_q;
   assign o_tx_tick   = tx_q;
   assign o_rx_sample = rx_q;
   assign o_div_err   = err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: directed scenarios plus random traffic against a
// time-based reference model (period start times, tick ordinals, fraction sums).
module tb_uart_baud_gen;

   localparam int OS = 16;
`ifdef UART_BAUD_FRAC_EN
   localparam bit FRAC_EN = 1'b1;
`else
   localparam bit FRAC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_enable;
   logic [15:0] i_div_int;
   logic [3:0]  i_div_frac;
   logic        i_div_load;
   logic        i_rx_resync;
   logic        o_os_tick;
   logic        o_tx_tick;
   logic        o_rx_sample;
   logic        o_div_err;

   uart_baud_gen dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_enable    (i_enable),
      .i_div_int   (i_div_int),
      .i_div_frac  (i_div_frac),
      .i_div_load  (i_div_load),
      .i_rx_resync (i_rx_resync),
      .o_os_tick   (o_os_tick),
      .o_tx_tick   (o_tx_tick),
      .o_rx_sample (o_rx_sample),
      .o_div_err   (o_div_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n = 0;

   // reference model state
   int m_int, m_frac, p_int, p_frac;
   bit p_v, m_err, ext;
   int acc, os_cnt, rx_cnt, pstart;
   bit e_os, e_tx, e_rx, e_err;

   int os_t[$];
   int tx_t[$];
   int rx_t[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_init();
      m_int = 14; m_frac = 0; p_v = 1'b0; p_int = 0; p_frac = 0; m_err = 1'b0;
      acc = 0; ext = 1'b0; os_cnt = 0; rx_cnt = 0; pstart = n;
      e_os = 1'b0; e_tx = 1'b0; e_rx = 1'b0; e_err = 1'b0;
   endtask

   function automatic int cur_period();
      return m_int + ((FRAC_EN && ext) ? 1 : 0);
   endfunction

   // One clock cycle: drive inputs, advance the model, check this cycle's outputs.
   task automatic step(input bit en, input bit ld, input bit rs, input int di, input int df);
      bit n_os, n_tx, n_rx, wrap;
      n_os = 1'b0; n_tx = 1'b0; n_rx = 1'b0; wrap = 1'b0;
      i_enable = en; i_div_load = ld; i_rx_resync = rs;
      i_div_int = 16'(di); i_div_frac = 4'(df);
      if (en) begin
         if (rs) begin
            pstart = n;
            rx_cnt = 0;
         end else if (n == pstart + cur_period() - 1) begin
            wrap = 1'b1;
            n_os = 1'b1;
            n_tx = (os_cnt % OS) == OS - 1;
            n_rx = (rx_cnt % OS) == OS / 2 - 1;
            os_cnt++;
            rx_cnt++;
            ext = (acc + m_frac) >= 16;
            acc = (acc + m_frac) % 16;
            pstart = n + 1;
         end
      end else begin
         pstart = n + 1; acc = 0; ext = 1'b0; os_cnt = 0; rx_cnt = 0;
      end
      if (ld && di >= 2) begin
         m_err = 1'b0;
         if (wrap || !en) begin
            m_int = di; m_frac = df; p_v = 1'b0;
         end else begin
            p_int = di; p_frac = df; p_v = 1'b1;
         end
      end else begin
         if (ld) m_err = 1'b1;
         if ((wrap || !en) && p_v) begin
            m_int = p_int; m_frac = p_frac; p_v = 1'b0;
         end
      end
      @(negedge clk);
      chk("os_tick", o_os_tick, e_os);
      chk("tx_tick", o_tx_tick, e_tx);
      chk("rx_sample", o_rx_sample, e_rx);
      chk("div_err", o_div_err, e_err);
      if (o_os_tick === 1'b1) os_t.push_back(n);
      if (o_tx_tick === 1'b1) tx_t.push_back(n);
      if (o_rx_sample === 1'b1) rx_t.push_back(n);
      @(posedge clk); #1;
      n++;
      e_os = n_os; e_tx = n_tx; e_rx = n_rx; e_err = m_err;
   endtask

   task automatic idle(input int k, input bit en);
      repeat (k) step(en, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic clear_times();
      os_t.delete(); tx_t.delete(); rx_t.delete();
   endtask

   initial begin
      int t0, r, gaps14, sel;
      bit en, found;
      reset_n = 1'b0; i_enable = 1'b0; i_div_load = 1'b0; i_rx_resync = 1'b0;
      i_div_int = 16'd0; i_div_frac = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_init();
      idle(2, 1'b0);

      // default divisor 14: first tick 14 cycles after enable, tx every 224
      clear_times(); t0 = n;
      idle(470, 1'b1);
      chk("first_os_after_enable", os_t[0] - t0, 14);
      chk("os_period_14", os_t[1] - os_t[0], 14);
      chk("tx_period_224", tx_t[1] - tx_t[0], 224);

      // rejected load keeps 14, accepted load of 20 takes over
      step(1'b1, 1'b1, 1'b0, 1, 0);
      chk("div_err_set", o_div_err, 1);
      clear_times();
      idle(60, 1'b1);
      chk("period_kept_14", os_t[os_t.size()-1] - os_t[os_t.size()-2], 14);
      step(1'b1, 1'b1, 1'b0, 20, 0);
      chk("div_err_clear", o_div_err, 0);
      clear_times();
      idle(90, 1'b1);
      chk("period_20", os_t[os_t.size()-1] - os_t[os_t.size()-2], 20);

      // resync at an arbitrary cycle with divisor 10
      step(1'b0, 1'b1, 1'b0, 10, 0);
      idle(30 + $urandom_range(40, 0), 1'b1);
      r = n;
      step(1'b1, 1'b0, 1'b1, 0, 0);
      clear_times();
      idle(400, 1'b1);
      chk("rx_80_after_resync", rx_t[0] - r, 80);
      chk("tx_spacing_160", tx_t[tx_t.size()-1] - tx_t[tx_t.size()-2], 160);

      // resync landing exactly on terminal count
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (n == pstart + cur_period() - 1) begin
            found = 1'b1;
            break;
         end
         idle(1, 1'b1);
      end
      chk("terminal_found", found, 1);
      r = n;
      step(1'b1, 1'b0, 1'b1, 0, 0);
      chk("no_os_on_tc_resync", o_os_tick, 0);
      clear_times();
      idle(100, 1'b1);
      chk("rx_80_after_tc_resync", rx_t[0] - r, 80);

`ifdef UART_BAUD_FRAC_EN
      // 13 + 9/16: sixteen periods add up to 217 cycles, nine of them 14 long
      step(1'b0, 1'b1, 1'b0, 13, 9);
      clear_times();
      idle(240, 1'b1);
      chk("frac_16_periods", os_t[16] - os_t[0], 217);
      gaps14 = 0;
      for (int i = 0; i < 16; i++) gaps14 += ((os_t[i+1] - os_t[i]) == 14) ? 1 : 0;
      chk("frac_long_periods", gaps14, 9);
`endif

      // reset while a tick is on the outputs
      step(1'b0, 1'b1, 1'b0, 7, 0);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (e_os) begin
            found = 1'b1;
            break;
         end
         idle(1, 1'b1);
      end
      chk("tick_pending_found", found, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_os", o_os_tick, 0);
      chk("rst_tx", o_tx_tick, 0);
      chk("rst_rx", o_rx_sample, 0);
      chk("rst_err", o_div_err, 0);
      repeat (2) begin
         @(posedge clk); #1;
         n++;
      end
      reset_n = 1'b1;
      model_init();
      clear_times(); t0 = n;
      idle(40, 1'b1);
      chk("first_os_after_reset", os_t[0] - t0, 14);
      chk("period_after_reset", os_t[1] - os_t[0], 14);

      // random traffic against the model
      en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         bit ld, rs;
         int di;
         if ($urandom_range(149, 0) == 0) en = ~en;
         ld = ($urandom_range(24, 0) == 0);
         rs = ($urandom_range(36, 0) == 0);
         sel = $urandom_range(5, 0);
         di = (sel == 0) ? $urandom_range(1, 0) : $urandom_range(5, 2);
         step(en, ld, rs, di, $urandom_range(15, 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
